// File: rtl/sevenseg_scan_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding a multiplexed common-anode 7-segment scan.
// Optional macro SEVENSEG_LZ_BLANK_EN enables leading-zero blanking (digit 0 is never blanked).
module sevenseg_scan_driver #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    // state     | meaning
    // S_IDLE    | waiting for load, display shows last committed value
    // S_CONVERT | one double-dabble iteration per cycle, BIN_W cycles
    // S_COMMIT  | copy BCD result and overflow flag to display registers
    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          IT_W      = $clog2(BIN_W + 1);
    localparam int          DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          PS_W      = $clog2(SCAN_DIV);
    localparam logic [63:0] OVF_LIMIT = 64'(10 ** DIGITS);

    state_t             state_q;
    logic               busy_q;
    logic [BIN_W-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [IT_W-1:0]    iter_q;
    logic               ovf_cap_q;
    logic [BCD_W-1:0]   disp_bcd_q;
    logic               disp_ovf_q;
    logic [PS_W-1:0]    presc_q;
    logic [DIG_W-1:0]   dig_q;
    logic [DIGITS-1:0]  an_q;
    logic [6:0]         seg_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_in;
    logic [3:0]         nib;
    logic               blank;
    logic [6:0]         seg_d;
    logic [DIGITS-1:0]  an_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    assign ovf_in = (64'(value) >= OVF_LIMIT);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_cap_q  <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        bin_q     <= value;
                        bcd_q     <= '0;
                        iter_q    <= IT_W'(BIN_W);
                        ovf_cap_q <= ovf_in;
                        busy_q    <= 1'b1;
                        state_q   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                    bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
                    iter_q <= iter_q - IT_W'(1);
                    // A carry out of the top nibble only happens for out-of-range values.
                    if (bcd_adj[BCD_W-1])
                        ovf_cap_q <= 1'b1;
                    if (iter_q == IT_W'(1))
                        state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    disp_bcd_q <= bcd_q;
                    disp_ovf_q <= ovf_cap_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (DIG_W'(i) == dig_q)
                nib = disp_bcd_q[4*i +: 4];
        end
    end

`ifdef SEVENSEG_LZ_BLANK_EN
    logic lead_zero;

    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (DIG_W'(i) >= dig_q && disp_bcd_q[4*i +: 4] != 4'd0)
                lead_zero = 1'b0;
        end
    end

    assign blank = lead_zero && (dig_q != '0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d = seg_decode(nib);
        if (disp_ovf_q)
            seg_d = 7'h3F;
        else if (blank)
            seg_d = 7'h7F;
    end

    assign an_d = ~(DIGITS'(1) << dig_q);

    // an/seg load the current index on a wrap, so the first wrap lights digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            dig_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
        end else if (presc_q == PS_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dig_q   <= (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    assign busy     = busy_q;
    assign overflow = disp_ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized self-checking bench for sevenseg_scan_driver; expected digits come from decimal arithmetic.
module tb_sevenseg_scan_driver;
    localparam int BIN_W    = 14;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int CONV_CYC = BIN_W + 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              load  = 1'b0;
    logic [BIN_W-1:0]  value = '0;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int n_cmp = 0;
    int n_bad = 0;
    int model_val = 0;

    logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .BIN_W   (BIN_W),
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .busy    (busy),
        .overflow(overflow),
        .seg     (seg),
        .an      (an)
    );

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        int p = pow10(d);
        if (v >= pow10(DIGITS)) return 7'h3F;
`ifdef SEVENSEG_LZ_BLANK_EN
        if (d != 0 && v < p) return 7'h7F;
`endif
        return seg_tab[(v / p) % 10];
    endfunction

    task automatic do_load(input int v);
        load  = 1'b1;
        value = v[BIN_W-1:0];
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic check_busy_len(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != CONV_CYC) begin
            n_bad++;
            $display("FAIL %s busy_len: got %0d cycles, want %0d", tag, n, CONV_CYC);
        end
    endtask

    task automatic check_display(input string tag);
        int prev_d = -1;
        int d, zeros, n;
        logic [DIGITS-1:0] prev_an;
        logic exp_ovf;
        repeat (8) @(negedge clk);
        exp_ovf = (model_val >= pow10(DIGITS));
        n_cmp++;
        if (overflow !== exp_ovf) begin
            n_bad++;
            $display("FAIL %s overflow: got %b, want %b", tag, overflow, exp_ovf);
        end
        for (int k = 0; k < DIGITS; k++) begin
            prev_an = an;
            n = 0;
            while (an === prev_an && n < 3 * SCAN_DIV) begin
                @(negedge clk);
                n++;
            end
            zeros = 0;
            d = -1;
            for (int b = 0; b < DIGITS; b++) begin
                if (an[b] === 1'b0) begin
                    zeros++;
                    d = b;
                end
            end
            n_cmp++;
            if (an === prev_an || zeros != 1) begin
                n_bad++;
                $display("FAIL %s an_onehot: got %b, want exactly one low bit after a change", tag, an);
                d = -1;
            end else begin
                if (prev_d >= 0) begin
                    n_cmp++;
                    if (d != (prev_d + 1) % DIGITS) begin
                        n_bad++;
                        $display("FAIL %s scan_order: got digit %0d, want %0d", tag, d, (prev_d + 1) % DIGITS);
                    end
                end
                n_cmp++;
                if (seg !== exp_seg(model_val, d)) begin
                    n_bad++;
                    $display("FAIL %s seg[%0d] value %0d: got %h, want %h", tag, d, model_val, seg, exp_seg(model_val, d));
                end
            end
            prev_d = d;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (busy !== 1'b0 || overflow !== 1'b0 || an !== '1 || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL %s reset_outputs: got busy=%b ovf=%b an=%b seg=%h, want 0 0 1111 7f",
                     tag, busy, overflow, an, seg);
        end
    endtask

    task automatic test_reset();
        logic [DIGITS-1:0] exp_an;
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k < SCAN_DIV) exp_an = '1;
            else exp_an = ~(DIGITS'(1) << ((k / SCAN_DIV - 1) % DIGITS));
            n_cmp++;
            if (an !== exp_an) begin
                n_bad++;
                $display("FAIL reset_scan an at cycle %0d: got %b, want %b", k, an, exp_an);
            end
            if (k >= SCAN_DIV) begin
                n_cmp++;
                if (seg !== exp_seg(0, (k / SCAN_DIV - 1) % DIGITS)) begin
                    n_bad++;
                    $display("FAIL reset_scan seg at cycle %0d: got %h, want %h", k, seg,
                             exp_seg(0, (k / SCAN_DIV - 1) % DIGITS));
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b ovf=%b, want 0 0", busy, overflow);
        end
    endtask

    task automatic test_convert(input int v, input string tag);
        do_load(v);
        check_busy_len(tag);
        model_val = v;
        check_display(tag);
    endtask

    task automatic test_ignored_load();
        int n;
        do_load(5678);
        repeat (2) @(negedge clk);
        load  = 1'b1;
        value = BIN_W'(42);
        @(negedge clk);
        load  = 1'b0;
        n = 3;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n != CONV_CYC) begin
            n_bad++;
            $display("FAIL ignored_load busy_len: got %0d, want %0d", n, CONV_CYC);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_load queued: got busy=%b, want 0", busy);
        end
        model_val = 5678;
        check_display("ignored_load");
    endtask

    task automatic test_back_to_back();
        int a = $urandom_range(0, 9999);
        int b = $urandom_range(0, 16383);
        do_load(a);
        repeat (CONV_CYC - 1) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b commit_busy: got %b, want 1", busy);
        end
        load  = 1'b1;
        value = b[BIN_W-1:0];
        @(negedge clk);
        load  = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b load_at_commit: got busy=%b, want 0", busy);
        end
        model_val = a;
        do_load(b);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b accept_when_idle: got busy=%b, want 1", busy);
        end
        check_busy_len("b2b");
        model_val = b;
        check_display("b2b");
    endtask

    task automatic test_reset_abort();
        test_convert(1234, "abort_pre");
        do_load(4321);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        model_val = 0;
        check_display("abort_post");
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = (i % 3 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
            test_convert(v, "random");
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_convert(1234, "v1234");
        test_convert(9999, "v9999");
        test_convert(10000, "v10000");
        test_convert(7, "v7");
        test_convert(0, "v0");
        test_convert(16383, "vmax");
        test_ignored_load();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
